// File: rtl/ram8_pkg.sv
// Shared constants and state encoding for the eight-word register bank.
package ram8_pkg;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

endpackage

// File: rtl/ram8_bank_reg_word.sv
// One data word: loadable register with an asynchronous active-low clear.
module reg_word #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q;

    // Capture d_i on load; the clear returns the word to zero.
    always_ff @(posedge clk or negedge clr_n_i) begin
        if (!clr_n_i) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/ram8_bank.sv
// Eight-word register bank with written flags, valid/ready request channel
// and a registered response channel.
module ram8_bank
    import ram8_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    input  logic              clr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_hit,
    output logic [DEPTH-1:0]  wr_onehot
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               hit_q,   hit_d;
    logic [DEPTH-1:0]   flag_q,  flag_d;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               accept;

    // Request side: free when empty, or when the held response leaves this cycle.
    assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;

    // Decoded word-load strobes for an accepted write.
    assign wr_onehot = (accept && req_we) ? (DEPTH'(1) << req_addr) : '0;

    // Word storage, one register per address, loaded by its strobe.
    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        reg_word #(.WIDTH(WIDTH)) u_word (
            .clk     (clk),
            .clr_n_i (rst_n),
            .load_i  (wr_onehot[k]),
            .d_i     (req_wdata),
            .q_o     (mem[k])
        );
    end

    // Next state, response payload and written flags; reads see pre-edge contents.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        hit_d   = hit_q;
        flag_d  = flag_q;

        if (clr) begin
            flag_d = '0;
        end

        if (accept) begin
            state_d = ST_RESP;
            if (req_we) begin
                flag_d[req_addr] = 1'b1;
                rdata_d          = req_wdata;
                hit_d            = 1'b1;
            end else begin
                rdata_d = mem[req_addr];
                hit_d   = flag_q[req_addr];
            end
        end else if ((state_q == ST_RESP) && rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    // State, response and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            flag_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            flag_q  <= flag_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_hit   = hit_q;

endmodule

// File: tb/tb_ram8_bank.sv
// Directed self-checking bench for ram8_bank.
module tb_ram8_bank;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic        clr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_hit;
    logic [7:0]  wr_onehot;

    int n_checks = 0;
    int n_fails  = 0;

    ram8_bank #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .clr       (clr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_hit   (rsp_hit),
        .wr_onehot (wr_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] a, input logic [15:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_hit",   32'(rsp_hit),   32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Read of an unwritten word.
        drive(1'b1, 1'b0, 3'd3, 16'h0);
        #1;
        check("rd3_ready",   32'(req_ready), 32'd1);
        check("rd3_onehot",  32'(wr_onehot), 32'h00);
        tick();
        check("rd3_valid",   32'(rsp_valid), 32'd1);
        check("rd3_rdata",   32'(rsp_rdata), 32'h0000);
        check("rd3_hit",     32'(rsp_hit),   32'd0);

        // Write BEEF to word 5, then read it back.
        drive(1'b1, 1'b1, 3'd5, 16'hBEEF);
        #1;
        check("wr5_ready",   32'(req_ready), 32'd1);
        check("wr5_onehot",  32'(wr_onehot), 32'h20);
        tick();
        check("wr5_rdata",   32'(rsp_rdata), 32'hBEEF);
        check("wr5_hit",     32'(rsp_hit),   32'd1);
        drive(1'b1, 1'b0, 3'd5, 16'h0);
        tick();
        check("rd5_rdata",   32'(rsp_rdata), 32'hBEEF);
        check("rd5_hit",     32'(rsp_hit),   32'd1);

        // Back-to-back writes to all words.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 3'(k), 16'h1000 + 16'(k));
            #1;
            check("b2b_wr_ready",  32'(req_ready), 32'd1);
            check("b2b_wr_onehot", 32'(wr_onehot), 32'(8'd1 << k));
            tick();
            check("b2b_wr_echo",   32'(rsp_rdata), 32'h1000 + 32'(k));
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 3'(k), 16'h0);
            #1;
            check("b2b_rd_ready", 32'(req_ready), 32'd1);
            tick();
            check("b2b_rd_rdata", 32'(rsp_rdata), 32'h1000 + 32'(k));
            check("b2b_rd_hit",   32'(rsp_hit),   32'd1);
        end

        // Backpressure: read word 2, stall, pending write must wait.
        drive(1'b1, 1'b0, 3'd2, 16'h0);
        tick();
        check("bp_rd_rdata", 32'(rsp_rdata), 32'h1002);
        rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 3'd2, 16'h5555);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp_ready",  32'(req_ready), 32'd0);
            check("bp_onehot", 32'(wr_onehot), 32'h00);
            tick();
            check("bp_valid",  32'(rsp_valid), 32'd1);
            check("bp_rdata",  32'(rsp_rdata), 32'h1002);
            check("bp_hit",    32'(rsp_hit),   32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_rel_ready",  32'(req_ready), 32'd1);
        check("bp_rel_onehot", 32'(wr_onehot), 32'h04);
        tick();
        check("bp_rel_rdata",  32'(rsp_rdata), 32'h5555);
        check("bp_rel_hit",    32'(rsp_hit),   32'd1);

        // Clear coinciding with a write to word 6.
        drive(1'b1, 1'b1, 3'd6, 16'h00AA);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_wr_rdata", 32'(rsp_rdata), 32'h00AA);
        check("clr_wr_hit",   32'(rsp_hit),   32'd1);
        drive(1'b1, 1'b0, 3'd1, 16'h0);
        tick();
        check("clr_rd1_hit",   32'(rsp_hit),   32'd0);
        check("clr_rd1_rdata", 32'(rsp_rdata), 32'h1001);
        drive(1'b1, 1'b0, 3'd6, 16'h0);
        tick();
        check("clr_rd6_hit",   32'(rsp_hit),   32'd1);
        check("clr_rd6_rdata", 32'(rsp_rdata), 32'h00AA);

        // Idle drain: response retires without a new request.
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        check("drain_valid", 32'(rsp_valid), 32'd0);

        // Reset while holding a response.
        drive(1'b1, 1'b1, 3'd4, 16'h1234);
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        rsp_ready = 1'b0;
        tick();
        check("rr_hold_valid", 32'(rsp_valid), 32'd1);
        check("rr_hold_rdata", 32'(rsp_rdata), 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_async_valid", 32'(rsp_valid), 32'd0);
        check("rr_async_rdata", 32'(rsp_rdata), 32'h0000);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 3'd4, 16'h0);
        tick();
        check("rr_rd4_valid", 32'(rsp_valid), 32'd1);
        check("rr_rd4_rdata", 32'(rsp_rdata), 32'h0000);
        check("rr_rd4_hit",   32'(rsp_hit),   32'd0);
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ram8_bank.md
# ram8_bank

Eight-word register bank (8 × WIDTH bits) with a valid/ready request channel and a registered response channel. It consumes the one-hot load strobes produced by the 8-way demultiplexer stage: a write's 3-bit address is decoded to one of eight word-register loads. Every word also carries a "written" flag, so reads report whether the word holds data written since reset or the last clear. It is the first stateful memory stage above the combinational routing gates.

## Interface
Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bank accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  3  word index 0..7.
- req_wdata  in  WIDTH  write data.
- clr  in  1  synchronous clear of all eight written flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  WIDTH  read data, or echoed write data.
- rsp_hit  out  1  written flag of the addressed word at accept time; always 1 for writes.
- wr_onehot  out  8  decoded load strobes this cycle. Bit k = 1 iff a write to word k is accepted.

## Operation
- States: IDLE (no response held) and RESP (response held on rsp_*).
- Accept condition: req_valid && req_ready.
- req_ready = (state == IDLE) || (state == RESP && rsp_ready). This gives full throughput, one request per cycle.
- Accepted write to address a:
  - mem[a] <= req_wdata and flag[a] <= 1.
  - rsp_rdata <= req_wdata and rsp_hit <= 1.
- Accepted read from address a:
  - rsp_rdata <= mem[a] and rsp_hit <= flag[a].
  - Both values are taken before any same-edge update.
- Transitions:
  - IDLE → RESP on accept.
  - RESP → RESP on accept with rsp_ready; the response is replaced.
  - RESP → IDLE when rsp_ready and no accept.
  - RESP holds while !rsp_ready; rsp_rdata and rsp_hit stay stable.
- wr_onehot is combinational: one-hot decode of req_addr, gated by req_valid && req_ready && req_we. Otherwise it is 8'b0.
- clr clears all flags on the next edge. If clr coincides with an accepted write to word a, flag[a] ends at 1 and all others end at 0. clr does not alter a response already latched.
- Read-after-write on consecutive cycles to the same word returns the new data. This holds because the write completes on the accepting edge.

## Timing
- Reset (async assert, sync deassert is the system's job):
  - state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_hit = 0.
  - All mem words = 0 and all flags = 0.
  - req_ready = 1 from the first cycle after release.
- Latency: a request accepted at edge N has rsp_valid = 1 after edge N, with data valid in the same cycle.
- Reset during RESP discards the response. rsp_valid drops immediately (asynchronously).
- rsp_valid never deasserts without rsp_ready, except on reset.
- req_addr is always in range (3 bits). No wrap or error case.

## Structure
- Package ram8_pkg contains:
  - DEPTH = 8 and ADDR_W = 3.
  - State enum typedef: ST_IDLE, ST_RESP.
- Sub-module reg_word: a WIDTH-bit register with a load enable and an asynchronous active-low clear. Instantiate it 8×, with its load driven by the matching wr_onehot bit.
- Flags are an 8-bit vector inside the top module.

## Test plan
- Reset, then read addr 3 → rsp_rdata = 0, rsp_hit = 0, one cycle after accept; req_ready = 1 throughout with rsp_ready = 1.
- Write 16'hBEEF to addr 5:
  - wr_onehot = 8'b0010_0000 in the accept cycle.
  - Response echoes BEEF with hit = 1.
  - Next-cycle read of addr 5 → BEEF with hit = 1.
- Back-to-back writes with rsp_ready = 1: word k = 16'h1000 + k for k = 0..7 on 8 consecutive cycles → req_ready stays 1 and the responses echo in order. Reads of 0..7 then return the same values.
- Backpressure:
  - Read addr 2 with rsp_ready = 0 for 4 cycles → rsp_valid stays 1, rsp_rdata is stable, req_ready = 0, and a pending write to addr 2 is not accepted (wr_onehot = 0).
  - After rsp_ready rises, the write is accepted in that same cycle.
- clr on the same edge as a write of 16'h00AA to addr 6, with words 1 and 6 previously written → afterwards a read of addr 1 gives hit = 0, and a read of addr 6 gives hit = 1 with data 00AA.
- Assert rst_n = 0 mid-RESP holding data 16'h1234 → rsp_valid = 0 at once; after release, a read of that address returns 0 with hit = 0.
